fwd_mux_reg: RTL and testbench
==============================

# fwd_mux_reg

Parametrised operand-forwarding selector with a registered output stage for the pipelined MIPS datapath. It sits at the D/E boundary and picks one operand from the register-file read value or from any of NSRC later pipeline stages, using destination-address match with youngest-stage priority. It detects a not-yet-ready forwarding source (load-use hazard), inserts a bubble, and holds or flushes its output register under pipeline control. It replaces the fixed 2/3-input operand muxes.

## Interface
- WIDTH, 32, operand data width
- AW, 5, register address width
- NSRC, 3, number of forwarding stages; index 0 = youngest (E), NSRC-1 = oldest (W)
- SW, $clog2(NSRC+1), select-code width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold output register (external busy, e.g. mult/div)
- flush  in  1  clear output register to bubble
- rs_addr  in  AW  source register address requested by D stage
- rf_data  in  WIDTH  register-file read data for rs_addr
- src_valid  in  NSRC  stage i writes a register
- src_addr  in  NSRC*AW  destination address of stage i, slice [i*AW +: AW]
- src_data  in  NSRC*WIDTH  result of stage i, slice [i*WIDTH +: WIDTH]
- src_ready  in  NSRC  result of stage i is available this cycle
- hazard  out  1  combinational; winning source not ready
- q  out  WIDTH  registered operand to E stage
- q_sel  out  SW  registered select code: 0..NSRC-1 = stage, NSRC = register file
- q_bubble  out  1  registered; E-stage slot holds a bubble
- hz_cnt  out  4  consecutive hazard cycles, saturating

## Operation
- Match i: src_valid[i] && src_addr[i]==rs_addr && rs_addr!=0.
- Winner: lowest matching index. No match, or rs_addr==0: select register file (code NSRC, data rf_data).
- rs_addr==0 never forwards, even when a source targets $0 with valid data.
- hazard = match exists && !src_ready[winner]. A ready younger stage masks an older unready one; an unready younger stage raises hazard even if an older stage matches.
- Register update priority per edge:
  - reset: q=0, q_sel=NSRC, q_bubble=1, hz_cnt=0
  - else flush: q=0, q_sel=NSRC, q_bubble=1; hz_cnt unchanged
  - else stall: hold q, q_sel, q_bubble, hz_cnt
  - else hazard: q=0, q_sel=NSRC, q_bubble=1, hz_cnt=min(hz_cnt+1,15)
  - else load: q=selected data, q_sel=winner code, q_bubble=0, hz_cnt=0
- Flush and hazard together give a bubble; hz_cnt is not incremented.
- hazard is purely combinational. It stays valid while stall=1; the upstream stall logic ORs it.

## Timing
- Select and hazard paths are combinational, with zero-cycle latency from inputs to hazard.
- q, q_sel, and q_bubble have one-cycle latency from the inputs sampled at the edge.
- A reset asserted mid-stall or mid-hazard wins on the next edge. All outputs reach their reset values one edge after reset is sampled high.
- hz_cnt saturates at 15 and does not wrap.
- Out-of-range or X src_* on unmatched lanes must not affect q.

## Structure
- Shared package/header fwd_pkg:
  - SEL_RF(NSRC) function/constant
  - HZ_CNT_W=4
  - HZ_CNT_MAX=15
- Sub-module fwd_prio_enc (NSRC, AW):
  - inputs: match vector
  - outputs: winner index, any_match
  - lowest-index-first priority
- Top level holds the data mux (indexed part-select), the hazard logic, and the output register.

## Test plan
1. reset=1 for 2 cycles, then 0 with stall=flush=0 and no matches. After reset: q=0, q_sel=3, q_bubble=1, hz_cnt=0. Next edge with rf_data=0x1234: q=0x1234, q_sel=3, q_bubble=0.
2. rs_addr=8; src0 and src2 both valid, addr 8, ready, data 0xAAAA/0xCCCC. Required: q=0xAAAA, q_sel=0. Repeat with src0 invalid: q=0xCCCC, q_sel=2.
3. rs_addr=0; src0 valid, addr 0, data 0xFFFF; rf_data=0. Required: q=0, q_sel=3, hazard=0.
4. Load-use: rs_addr=5, src0 valid, addr 5, ready=0, for 3 cycles. Required: hazard=1 each cycle, q_bubble=1, hz_cnt 1,2,3. Then ready=1, data 0x55: q=0x55, q_sel=0, hz_cnt=0. Hold hazard for 20 cycles: hz_cnt stops at 15.
5. After a load of q=0x77, stall=1 for 4 cycles while inputs change. Required: q=0x77, q_sel, and hz_cnt held. Assert stall and flush together: q=0, q_bubble=1.
6. Assert reset during an active hazard with hz_cnt=6 and stall=1. Next edge: all outputs at reset values, hz_cnt=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants for the operand-forwarding selector.
package fwd_pkg;

  // Width and ceiling of the consecutive-hazard counter.
  localparam int                  HZ_CNT_W   = 4;
  localparam logic [HZ_CNT_W-1:0] HZ_CNT_MAX = 4'd15;

  // Select code meaning "register file": one past the last forwarding stage.
  function automatic int sel_rf(input int nsrc);
    return nsrc;
  endfunction

endpackage

// File: rtl/fwd_prio_enc.sv
// Lowest-index-first priority encoder over the forwarding match vector.
// Index 0 is the youngest stage, so the youngest matching producer wins.
module fwd_prio_enc #(
  parameter  int NSRC = 3,
  localparam int SW   = $clog2(NSRC + 1)
) (
  input  logic [NSRC-1:0] i_match,
  output logic [SW-1:0]   o_idx,
  output logic            o_any
);

  // Scan from oldest to youngest so the last hit taken is the lowest index.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_match[i]) begin
        o_idx = SW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_mux_reg.sv
// Operand-forwarding selector with registered output stage (D/E boundary).
// Picks the rs operand from the youngest matching later stage, or from the
// register file. Flags a load-use hazard when the winning stage has no result
// yet, and turns that cycle into a bubble in the output register.
//
// Source handshake: src_valid[i] means stage i will write register
// src_addr[i]; src_ready[i] means its result src_data[i] is available in the
// current cycle. A valid-but-not-ready winner is a hazard. Lanes that do not
// win the match never reach q, whatever their address or data.
module fwd_mux_reg
  import fwd_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int AW    = 5,
  parameter  int NSRC  = 3,
  localparam int SW    = $clog2(NSRC + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [AW-1:0]         rs_addr,
  input  logic [WIDTH-1:0]      rf_data,
  input  logic [NSRC-1:0]       src_valid,
  input  logic [NSRC*AW-1:0]    src_addr,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_ready,
  output logic                  hazard,
  output logic [WIDTH-1:0]      q,
  output logic [SW-1:0]         q_sel,
  output logic                  q_bubble,
  output logic [HZ_CNT_W-1:0]   hz_cnt
);

  localparam logic [SW-1:0] SEL_RF = SW'(sel_rf(NSRC));

  logic [NSRC-1:0]     w_match;
  logic [SW-1:0]       w_win;
  logic                w_any;
  logic [WIDTH-1:0]    w_sel_data;
  logic [SW-1:0]       w_sel_code;
  logic                w_hazard;

  logic [WIDTH-1:0]    r_q;
  logic [SW-1:0]       r_q_sel;
  logic                r_q_bubble;
  logic [HZ_CNT_W-1:0] r_hz_cnt;

  // Per-stage address match; register $0 is hard-wired and never forwards.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_match[i] = src_valid[i] && (src_addr[i*AW +: AW] == rs_addr) && (rs_addr != '0);
    end
  end

  fwd_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .i_match (w_match),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // Operand mux: only the winning lane's data is selected.
  always_comb begin
    w_sel_data = rf_data;
    w_sel_code = SEL_RF;
    if (w_any) begin
      w_sel_data = src_data[w_win*WIDTH +: WIDTH];
      w_sel_code = w_win;
    end
  end

  // Hazard only looks at the winner: a ready younger stage masks an older one.
  assign w_hazard = w_any && !src_ready[w_win];
  assign hazard   = w_hazard;

  // Output register: reset > flush > stall > hazard bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= '0;
      r_q_sel    <= SEL_RF;
      r_q_bubble <= 1'b1;
      r_hz_cnt   <= '0;
    end else if (flush) begin
      r_q        <= '0;
      r_q_sel    <= SEL_RF;
      r_q_bubble <= 1'b1;
    end else if (stall) begin
      r_q        <= r_q;
      r_q_sel    <= r_q_sel;
      r_q_bubble <= r_q_bubble;
      r_hz_cnt   <= r_hz_cnt;
    end else if (w_hazard) begin
      r_q        <= '0;
      r_q_sel    <= SEL_RF;
      r_q_bubble <= 1'b1;
      r_hz_cnt   <= (r_hz_cnt == HZ_CNT_MAX) ? r_hz_cnt : r_hz_cnt + 1'b1;
    end else begin
      r_q        <= w_sel_data;
      r_q_sel    <= w_sel_code;
      r_q_bubble <= 1'b0;
      r_hz_cnt   <= '0;
    end
  end

  assign q        = r_q;
  assign q_sel    = r_q_sel;
  assign q_bubble = r_q_bubble;
  assign hz_cnt   = r_hz_cnt;

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Scoreboard bench for fwd_mux_reg: directed scenarios then random traffic,
// checked against a behavioural model of the forwarding rules.
module tb_fwd_mux_reg;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int NSRC  = 3;
  localparam int SW    = 2;
  localparam int EW    = WIDTH + SW + 1 + 4;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  stall = 1'b0;
  logic                  flush = 1'b0;
  logic [AW-1:0]         rs_addr = '0;
  logic [WIDTH-1:0]      rf_data = '0;
  logic [NSRC-1:0]       src_valid = '0;
  logic [NSRC*AW-1:0]    src_addr = '0;
  logic [NSRC*WIDTH-1:0] src_data = '0;
  logic [NSRC-1:0]       src_ready = '0;
  logic                  hazard;
  logic [WIDTH-1:0]      q;
  logic [SW-1:0]         q_sel;
  logic                  q_bubble;
  logic [3:0]            hz_cnt;

  always #5 clk = ~clk;

  fwd_mux_reg #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .rs_addr   (rs_addr),
    .rf_data   (rf_data),
    .src_valid (src_valid),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .src_ready (src_ready),
    .hazard    (hazard),
    .q         (q),
    .q_sel     (q_sel),
    .q_bubble  (q_bubble),
    .hz_cnt    (hz_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state (what the E-stage register should hold).
  logic [WIDTH-1:0] m_q = '0;
  int               m_sel = NSRC;
  logic             m_bub = 1'b1;
  int               m_cnt = 0;

  // ---------------- driver ----------------
  // Apply one cycle of inputs, check hazard, predict the register contents
  // after the next rising edge and queue that prediction.
  task automatic step(input logic rst, input logic stl, input logic fl,
                      input logic [AW-1:0] rs, input logic [WIDTH-1:0] rf,
                      input logic [NSRC-1:0] v, input logic [NSRC*AW-1:0] a,
                      input logic [NSRC*WIDTH-1:0] d, input logic [NSRC-1:0] rdy);
    int win;
    logic exp_hz;
    logic [WIDTH-1:0] lane_data;
    logic [AW-1:0] lane_addr;
    @(negedge clk);
    reset = rst; stall = stl; flush = fl; rs_addr = rs; rf_data = rf;
    src_valid = v; src_addr = a; src_data = d; src_ready = rdy;
    #1;
    // Youngest stage writing the requested register wins; $0 never forwards.
    win = -1;
    if (rs != 0) begin
      for (int i = 0; i < NSRC; i++) begin
        lane_addr = a[i*AW +: AW];
        if (win < 0 && v[i] && lane_addr == rs) win = i;
      end
    end
    exp_hz = (win >= 0) && !rdy[win];
    checks++;
    if (hazard !== exp_hz) begin
      errors++;
      $display("FAIL hazard got=%b exp=%b at %0t", hazard, exp_hz, $time);
    end
    if (rst) begin
      m_q = '0; m_sel = NSRC; m_bub = 1'b1; m_cnt = 0;
    end else if (fl) begin
      m_q = '0; m_sel = NSRC; m_bub = 1'b1;
    end else if (stl) begin
      // everything held
    end else if (exp_hz) begin
      m_q = '0; m_sel = NSRC; m_bub = 1'b1;
      m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    end else begin
      lane_data = (win >= 0) ? d[win*WIDTH +: WIDTH] : rf;
      m_q = lane_data; m_sel = (win >= 0) ? win : NSRC; m_bub = 1'b0; m_cnt = 0;
    end
    exp_q.push_back({m_q, SW'(m_sel), m_bub, 4'(m_cnt)});
  endtask

  // ---------------- monitor ----------------
  // The register presents a new value after each rising edge.
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {q, q_sel, q_bubble, hz_cnt};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL regs got q=%h sel=%0d bub=%b cnt=%0d exp q=%h sel=%0d bub=%b cnt=%0d at %0t",
                   q, q_sel, q_bubble, hz_cnt,
                   e[EW-1 -: WIDTH], e[6:5], e[4], e[3:0], $time);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  localparam logic [NSRC*AW-1:0]    A0 = '0;
  localparam logic [NSRC*WIDTH-1:0] D0 = '0;

  initial begin
    // 1: reset, then a plain register-file load.
    step(1, 0, 0, 0, 0, 0, A0, D0, 0);
    step(1, 0, 0, 0, 0, 0, A0, D0, 0);
    step(0, 0, 0, 5'd3, 32'h1234, 0, A0, D0, 0);

    // 2: youngest of two matches wins; then the older one alone.
    step(0, 0, 0, 5'd8, 32'h9999, 3'b101, {5'd8, 5'd0, 5'd8},
         {32'hCCCC, 32'h0, 32'hAAAA}, 3'b111);
    step(0, 0, 0, 5'd8, 32'h9999, 3'b100, {5'd8, 5'd0, 5'd8},
         {32'hCCCC, 32'h0, 32'hAAAA}, 3'b111);

    // 3: $0 never forwards.
    step(0, 0, 0, 5'd0, 32'h0, 3'b001, {5'd0, 5'd0, 5'd0},
         {32'h0, 32'h0, 32'hFFFF}, 3'b111);

    // 4: load-use hazard, release, then saturation.
    repeat (3) step(0, 0, 0, 5'd5, 32'h1, 3'b001, {5'd0, 5'd0, 5'd5},
                    {32'h0, 32'h0, 32'h55}, 3'b000);
    step(0, 0, 0, 5'd5, 32'h1, 3'b001, {5'd0, 5'd0, 5'd5},
         {32'h0, 32'h0, 32'h55}, 3'b001);
    repeat (20) step(0, 0, 0, 5'd5, 32'h1, 3'b001, {5'd0, 5'd0, 5'd5},
                     {32'h0, 32'h0, 32'h55}, 3'b000);
    // Ready younger stage masks an unready older one; unready younger blocks.
    step(0, 0, 0, 5'd7, 32'h1, 3'b101, {5'd7, 5'd0, 5'd7},
         {32'h22, 32'h0, 32'h11}, 3'b001);
    step(0, 0, 0, 5'd7, 32'h1, 3'b101, {5'd7, 5'd0, 5'd7},
         {32'h22, 32'h0, 32'h11}, 3'b100);

    // 5: load 0x77, stall with changing inputs, then stall+flush.
    step(0, 0, 0, 5'd9, 32'h77, 0, A0, D0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 5'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)),
           15'($urandom), {$urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)));
    step(0, 1, 1, 5'd5, 32'h1, 3'b001, {5'd0, 5'd0, 5'd5}, D0, 3'b000);

    // 6: build hz_cnt to 6, then reset under stall with hazard still present.
    repeat (6) step(0, 0, 0, 5'd5, 32'h1, 3'b001, {5'd0, 5'd0, 5'd5}, D0, 3'b000);
    step(1, 1, 0, 5'd5, 32'h1, 3'b001, {5'd0, 5'd0, 5'd5}, D0, 3'b000);

    // Random traffic on a small address range to get frequent matches.
    for (int n = 0; n < 400; n++) begin
      logic [NSRC*AW-1:0] ra;
      for (int i = 0; i < NSRC; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 4));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), AW'($urandom_range(0, 4)), $urandom,
           NSRC'($urandom_range(0, 7)), ra, {$urandom, $urandom, $urandom},
           NSRC'($urandom_range(0, 7)));
    end

    // Let the monitor drain the last prediction.
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
